btn_debounce_multi: RTL



---
 rtl/btn_debounce_multi.sv | 108 ++++++++++
 1 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: 2-FF sync, tick-gated stability count, level + edge pulses.
// Optional `AUTO_REPEAT_EN adds hold/auto-repeat press pulses. Release pulses exit on release_pulse.
module btn_debounce_multi #(
   parameter int unsigned N_CH           = 4,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned HOLD_TICKS     = 8,
   parameter int unsigned REPEAT_TICKS   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sample_tick,
   input  logic [N_CH-1:0] button,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

   // Elaboration-time guard on the supported parameter ranges.
   if (N_CH < 1 || N_CH > 16 || DEBOUNCE_TICKS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1)
   begin : g_bad_param
      $error("btn_debounce_multi: parameter out of range");
   end

   logic [N_CH-1:0]            s1_q, s2_q;
   logic [N_CH-1:0]            level_q, level_d;
   logic [N_CH-1:0]            press_q, press_d;
   logic [N_CH-1:0]            rel_q, rel_d;
   logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [N_CH-1:0][HOLD_W-1:0] hold_q, hold_d;
`endif

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = '0;
      rel_d   = '0;
`ifdef AUTO_REPEAT_EN
      hold_d  = hold_q;
`endif
      for (int i = 0; i < N_CH; i++) begin
         if (sample_tick) begin
            if (s2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_W'(DEBOUNCE_TICKS - 1)) begin
               level_d[i] = s2_q[i];
               cnt_d[i]   = '0;
               press_d[i] = s2_q[i];
               rel_d[i]   = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
`ifdef AUTO_REPEAT_EN
            // Down-counter: loaded with HOLD_TICKS on the debounced rise, REPEAT_TICKS after.
            if (level_d[i] && !level_q[i]) begin
               hold_d[i] = HOLD_W'(HOLD_TICKS);
            end else if (!level_d[i]) begin
               hold_d[i] = '0;
            end else if (hold_q[i] <= HOLD_W'(1)) begin
               press_d[i] = 1'b1;
               hold_d[i]  = HOLD_W'(REPEAT_TICKS);
            end else begin
               hold_d[i] = hold_q[i] - 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= button;
         s2_q    <= s1_q;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = rel_q;

endmodule
